// File: rtl/feature_map_writer.sv
// Assembles a convolution feature map from half-row segments streamed in by a producer.
// Row/half counters drive the producer's row select; the finished map is held until overwritten.
module feature_map_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5,
  localparam int OH        = H - F + 1,
  localparam int OW        = W - F + 1,
  localparam int HALF      = OW / 2,
  localparam int SEG       = HALF * DATA_WIDTH,
  localparam int MAP       = OH * OW * DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEG-1:0]   in_data,
  output logic [5:0]       row_number,
  output logic [5:0]       column,
  output logic [MAP-1:0]   feature_map,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int AW = $clog2(MAP);
  localparam logic [5:0] LAST_ROW = 6'(OH - 1);

  state_t        state;
  logic [AW-1:0] seg_lsb;

  // Handshake: a segment is accepted on any rising edge where in_valid and
  // in_ready are both high; in_ready depends on state only, never on in_valid.
  assign in_ready  = (state == COLLECT);
  assign state_dbg = state;

  // Element 0 sits in the most-significant slice, so the segment's low vector
  // bit is counted down from the top of the map.
  always_comb begin
    seg_lsb = AW'(MAP - SEG - (int'(row_number) * OW + int'(column) * HALF) * DATA_WIDTH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      row_number  <= 6'd0;
      column      <= 6'd0;
      feature_map <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= COLLECT;
            busy       <= 1'b1;
            row_number <= 6'd0;
            column     <= 6'd0;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            feature_map[seg_lsb +: SEG] <= in_data;
            if (column == 6'd0) begin
              column <= 6'd1;
            end else if (row_number != LAST_ROW) begin
              row_number <= row_number + 6'd1;
              column     <= 6'd0;
            end else begin
              // Counters stay parked on the last segment while DONE holds.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            state      <= COLLECT;
            busy       <= 1'b1;
            done       <= 1'b0;
            row_number <= 6'd0;
            column     <= 6'd0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/feature_map_writer.md
FEATURE_MAP_WRITER -- requirements
Module: feature_map_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the bit width of one feature-map element.
REQ-002 Parameter H, default 32, SHALL set the input image height.
REQ-003 Parameter W, default 32, SHALL set the input image width.
REQ-004 Parameter F, default 5, SHALL set the filter size; derived OH=H-F+1, OW=W-F+1, HALF=OW/2 (defaults 28, 28, 14).
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  SHALL be the reset: asynchronous, active-low.
REQ-007 start  input  1  SHALL be a one-cycle pulse that begins assembly of a new feature map.
REQ-008 in_valid  input  1  SHALL indicate in_data holds one half-row of convolution results.
REQ-009 in_ready  output  1  SHALL indicate the block accepts a segment this cycle.
REQ-010 in_data  input  HALF*DATA_WIDTH  SHALL carry HALF elements, element 0 in the most-significant slice, bit 0 the MSB.
REQ-011 row_number  output  6  SHALL give the output row the next segment belongs to; it drives the producer's row select.
REQ-012 column  output  6  SHALL give the half select: 0 for columns 0..HALF-1, 1 for columns HALF..OW-1.
REQ-013 feature_map  output  OH*OW*DATA_WIDTH  SHALL be the assembled map, row-major, element (r,c) at bit offset (r*OW+c)*DATA_WIDTH, bit 0 the MSB.
REQ-014 busy  output  1  SHALL be high while in COLLECT.
REQ-015 done  output  1  SHALL be high while in DONE.

Function
REQ-016 FSM states SHALL be IDLE, COLLECT and DONE.
REQ-017 IDLE: start SHALL move the FSM to COLLECT on the next edge and clear row_number and column to 0.
REQ-018 DONE: start SHALL move the FSM to COLLECT with row_number=0, column=0; without start, DONE SHALL hold indefinitely.
REQ-019 start during COLLECT SHALL be ignored.
REQ-020 in_ready SHALL equal busy (combinational from state only, not from in_valid).
REQ-021 Accept SHALL occur on an edge where in_valid and in_ready are both high; no other edge writes feature_map.
REQ-022 On accept, HALF*DATA_WIDTH bits of in_data SHALL be written to feature_map at bit offset (row_number*OW + column*HALF)*DATA_WIDTH, visible the cycle after accept.
REQ-023 Bits of feature_map outside the written segment SHALL be unchanged on accept.
REQ-024 On accept with column=0, column SHALL become 1 and row_number SHALL hold.
REQ-025 On accept with column=1 and row_number<OH-1, column SHALL become 0 and row_number SHALL increment.
REQ-026 On accept with column=1 and row_number=OH-1, the FSM SHALL enter DONE; row_number and column SHALL hold at OH-1 and 1.
REQ-027 done SHALL rise in the cycle after the final accept; exactly 2*OH accepts complete one map.
REQ-028 in_valid outside COLLECT SHALL be ignored: no write and no counter change.
REQ-029 in_valid held low in COLLECT SHALL stall the block indefinitely with row_number, column and feature_map held.
REQ-030 Back-to-back accepts SHALL sustain one segment per cycle; minimum map time is 2*OH cycles after entering COLLECT.
REQ-031 feature_map SHALL NOT be cleared by start; previous-map contents persist until overwritten.

Reset
REQ-032 reset low SHALL immediately force IDLE, with busy=0, done=0, in_ready=0, row_number=0, column=0 and feature_map all zeros, independent of clk.
REQ-033 reset asserted mid-COLLECT SHALL abandon the partial map; after release the block SHALL wait in IDLE for start.
REQ-034 An accept edge coincident with reset assertion SHALL NOT write feature_map.

Verification
REQ-035 Reset, start, then 56 back-to-back segments where element value = r*28+c -> done high 57 cycles after COLLECT entry; every element (r,c) of feature_map equals r*28+c.
REQ-036 Random in_valid gaps during a full map -> row_number and column sequence (0,0),(0,1),(1,0)...(27,1) advances only on accepts; final map identical to REQ-035.
REQ-037 Apply in_valid=1 with data 0xDEADBEEF in IDLE and in DONE -> feature_map unchanged, in_ready=0.
REQ-038 Assert reset after 20 accepts -> feature_map all zero, state IDLE, row_number=0, column=0; a new full map then completes correctly.
REQ-039 From DONE, start with all segments 0xFFFFFFFF -> second map fully overwrites the first; pulse start mid-COLLECT -> no counter reset.
